// File: rtl/mat_operand_loader_pkg.sv
// Shared types and sizing helpers for the matrix operand loader and its downstream tracker.
package mat_operand_loader_pkg;

    // Loader state encoding, also decoded by the downstream latency tracker.
    typedef enum logic [1:0] {
        ST_LOAD_LHS = 2'd0,
        ST_LOAD_RHS = 2'd1,
        ST_HOLD     = 2'd2,
        ST_DRAIN    = 2'd3
    } load_state_e;

    function automatic int unsigned elem_width(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int unsigned mat_width(input int unsigned rows, input int unsigned cols,
                                              input int unsigned w);
        return rows * cols * w;
    endfunction

    // Counter width covering both operand sizes; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mat_operand_loader.sv
// Element-serial feeder for mat_mul: fills LHS then RHS row-major and holds both until released.
module mat_operand_loader
    import mat_operand_loader_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 23,
    parameter int unsigned BIAS       = 127,
    parameter int unsigned I          = 4,
    parameter int unsigned J          = 4,
    parameter int unsigned K          = 4
) (
    input  logic                                                         clk,
    input  logic                                                         rst_n,
    input  logic                                                         in_valid,
    output logic                                                         in_ready,
    input  logic [elem_width(EXP_WIDTH, FRAC_WIDTH)-1:0]                 in_data,
    input  logic                                                         in_last,
    output logic [mat_width(I, J, elem_width(EXP_WIDTH, FRAC_WIDTH))-1:0] lhs,
    output logic [mat_width(J, K, elem_width(EXP_WIDTH, FRAC_WIDTH))-1:0] rhs,
    output logic                                                         out_valid,
    input  logic                                                         out_ready,
    output logic                                                         frame_err
);

    localparam int unsigned W     = elem_width(EXP_WIDTH, FRAC_WIDTH);
    localparam int unsigned N_LHS = I * J;
    localparam int unsigned N_RHS = J * K;
    localparam int unsigned IDX_W = idx_width(N_LHS, N_RHS);

    localparam logic [IDX_W-1:0] LHS_LAST = IDX_W'(N_LHS - 1);
    localparam logic [IDX_W-1:0] RHS_LAST = IDX_W'(N_RHS - 1);

    // Bias only travels with the format parameters; nothing here does exponent arithmetic.
    if (BIAS == 0) begin : g_unbiased_format
    end

    load_state_e      state;
    logic [IDX_W-1:0] idx;
    logic             accept_c;

    assign accept_c = in_valid & in_ready;

    // Row-major flat index equals r*cols + c, so idx addresses the element slot directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD_LHS;
            idx       <= '0;
            lhs       <= '0;
            rhs       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_LOAD_LHS: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        if (in_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end else begin
                            lhs[int'(idx) * W +: W] <= in_data;
                            if (idx == LHS_LAST) begin
                                idx   <= '0;
                                state <= ST_LOAD_RHS;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                ST_LOAD_RHS: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        if (idx == RHS_LAST) begin
                            rhs[int'(idx) * W +: W] <= in_data;
                            idx <= '0;
                            if (in_last) begin
                                state     <= ST_HOLD;
                                out_valid <= 1'b1;
                                in_ready  <= 1'b0;
                            end else begin
                                state     <= ST_DRAIN;
                                frame_err <= 1'b1;
                            end
                        end else if (in_last) begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                            state     <= ST_LOAD_LHS;
                        end else begin
                            rhs[int'(idx) * W +: W] <= in_data;
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                        state     <= ST_LOAD_LHS;
                    end
                end
                ST_DRAIN: begin
                    in_ready <= 1'b1;
                    if (accept_c && in_last) begin
                        idx   <= '0;
                        state <= ST_LOAD_LHS;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    idx       <= '0;
                    state     <= ST_LOAD_LHS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed and randomized checks of mat_operand_loader at I=J=K=2, 32-bit elements.
module tb_mat_operand_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [127:0] lhs;
    logic [127:0] rhs;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;

    int total = 0;
    int bad   = 0;
    int err_pulses = 0;
    int releases   = 0;
    bit rand_or   = 1'b0;
    bit or_manual = 1'b0;

    always #5 clk = ~clk;

    mat_operand_loader #(
        .EXP_WIDTH (8),
        .FRAC_WIDTH(23),
        .BIAS      (127),
        .I         (2),
        .J         (2),
        .K         (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .lhs      (lhs),
        .rhs      (rhs),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Frame-level model: collect accepted words, judge the frame when the 8th arrives.
    logic [31:0]  mbuf[$];
    bit           m_hold  = 1'b0;
    bit           m_drain = 1'b0;
    bit           m_rdy   = 1'b0;
    bit           m_err   = 1'b0;
    logic [127:0] m_lhs   = '0;
    logic [127:0] m_rhs   = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mbuf.delete();
            m_hold  = 1'b0;
            m_drain = 1'b0;
            m_rdy   = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid && m_rdy) begin
                if (m_drain) begin
                    if (in_last) m_drain = 1'b0;
                end else if (mbuf.size() == 7) begin
                    if (in_last) begin
                        mbuf.push_back(in_data);
                        m_lhs  = {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
                        m_rhs  = {mbuf[7], mbuf[6], mbuf[5], mbuf[4]};
                        m_hold = 1'b1;
                    end else begin
                        m_err   = 1'b1;
                        m_drain = 1'b1;
                    end
                    mbuf.delete();
                end else if (in_last) begin
                    m_err = 1'b1;
                    mbuf.delete();
                end else begin
                    mbuf.push_back(in_data);
                end
            end
            m_rdy = !m_hold;
        end
    end

    // Per-cycle comparison against the model, plus DUT-side bus stability while valid.
    logic [127:0] prev_lhs = '0;
    logic [127:0] prev_rhs = '0;
    bit           prev_ov  = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", 128'(out_valid), 128'(m_hold));
            chk("in_ready", 128'(in_ready), 128'(m_rdy));
            chk("frame_err", 128'(frame_err), 128'(m_err));
            if (m_hold) begin
                chk("lhs", lhs, m_lhs);
                chk("rhs", rhs, m_rhs);
            end
            if (prev_ov && out_valid) begin
                chk("lhs_stable", lhs, prev_lhs);
                chk("rhs_stable", rhs, prev_rhs);
            end
            if (frame_err) err_pulses++;
            prev_ov  = out_valid;
            prev_lhs = lhs;
            prev_rhs = rhs;
        end else begin
            prev_ov = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst_n && out_valid && out_ready) releases++;
    end

    initial forever begin
        @(negedge clk);
        #1;
        out_ready = rand_or ? ($urandom_range(0, 9) < 3) : or_manual;
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [31:0] d, input bit last);
        bit ok;
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!ok && n < 100) begin
            ok = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_accept required=accept data=%h", d);
        end
    endtask

    task automatic send_frame(input logic [31:0] base);
        for (int i = 0; i < 8; i++) send(base + 32'(i), i == 7);
    endtask

    task automatic release_frame();
        or_manual = 1'b1;
        @(negedge clk);
        or_manual = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] fv [8];
        int e0;
        int r0;
        int n;
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_frame_err", 128'(frame_err), 128'd0);
        chk("rst_lhs", lhs, 128'd0);
        chk("rst_rhs", rhs, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: float frame, held under out_ready=0 while in_valid keeps toggling garbage
        for (int i = 0; i < 8; i++) send(fv[i], i == 7);
        chk("t1_ov_latency", 128'(out_valid), 128'd1);
        chk("t1_lhs", lhs, 128'h40800000_40400000_40000000_3F800000);
        chk("t1_rhs", rhs, 128'h41000000_40E00000_40C00000_40A00000);
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_data  = 32'hDEADBEEF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t1_hold_ov", 128'(out_valid), 128'd1);
        chk("t1_hold_lhs", lhs, 128'h40800000_40400000_40000000_3F800000);

        // 2: single-cycle release, then a back-to-back frame
        or_manual = 1'b1;
        @(negedge clk);
        or_manual = 1'b0;
        chk("t2_ov_drop", 128'(out_valid), 128'd0);
        chk("t2_in_ready", 128'(in_ready), 128'd1);
        send_frame(32'h00000010);
        chk("t2_lhs", lhs, 128'h00000013_00000012_00000011_00000010);
        chk("t2_rhs", rhs, 128'h00000017_00000016_00000015_00000014);
        release_frame();

        // 3: early last on the 3rd element
        e0 = err_pulses;
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b1);
        send_frame(32'h00000100);
        chk("t3_err_count", 128'(err_pulses - e0), 128'd1);
        chk("t3_ov", 128'(out_valid), 128'd1);
        chk("t3_lhs", lhs, 128'h00000103_00000102_00000101_00000100);
        release_frame();

        // 4: missing last, drain two elements, then a good frame
        e0 = err_pulses;
        for (int i = 0; i < 8; i++) send(32'hB0 + 32'(i), 1'b0);
        send(32'hC0, 1'b0);
        send(32'hC1, 1'b1);
        chk("t4_ov_after_drain", 128'(out_valid), 128'd0);
        send_frame(32'h00000200);
        chk("t4_err_count", 128'(err_pulses - e0), 128'd1);
        chk("t4_rhs", rhs, 128'h00000207_00000206_00000205_00000204);
        release_frame();

        // 5: reset after five accepts
        for (int i = 0; i < 5; i++) send(32'hE0 + 32'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ov", 128'(out_valid), 128'd0);
        chk("t5_rst_ready", 128'(in_ready), 128'd0);
        chk("t5_rst_err", 128'(frame_err), 128'd0);
        chk("t5_rst_lhs", lhs, 128'd0);
        chk("t5_rst_rhs", rhs, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e0 = err_pulses;
        send_frame(32'h00000300);
        chk("t5_lhs", lhs, 128'h00000303_00000302_00000301_00000300);
        chk("t5_rhs", rhs, 128'h00000307_00000306_00000305_00000304);
        chk("t5_no_err", 128'(err_pulses - e0), 128'd0);
        release_frame();

        // 6: random valid/ready duty over 200 frames
        r0 = releases;
        rand_or = 1'b1;
        for (int f = 0; f < 200; f++) begin
            for (int e = 0; e < 8; e++) begin
                if ($urandom_range(0, 1) == 0) @(negedge clk);
                send($urandom, e == 7);
            end
        end
        n = 0;
        while (out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        rand_or = 1'b0;
        @(negedge clk);
        chk("t6_releases", 128'(releases - r0), 128'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
